// File: rtl/mem_bus_initiator_pkg.sv
// Shared definitions for the peripheral enable/ready bus initiator: FSM state encoding and
// default bus widths used by the initiator and its request FIFO.
package mem_bus_initiator_pkg;

  localparam int unsigned DefAddrW     = 3;
  localparam int unsigned DefDataW     = 8;
  localparam int unsigned DefFifoDepth = 4;
  localparam int unsigned DefTimeout   = 255;

  // Idle: waiting for a queued request; Issue: bus_enable high; Release: waiting for ready low
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StRelease = 2'd2
  } state_e;

endpackage

// File: rtl/mem_bus_initiator_req_fifo.sv
// Synchronous request FIFO for the bus initiator. Full/empty come from an occupancy counter;
// a push into a full FIFO is dropped even if a pop happens in the same cycle.
module bus_req_fifo
  import mem_bus_initiator_pkg::*;
#(
  parameter int unsigned WIDTH = 1 + DefAddrW + DefDataW,
  parameter int unsigned DEPTH = DefFifoDepth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_initiator.sv
// Enable/ready bus initiator: queues read/write requests, runs each on the bus with a
// registered enable strobe, and retires it with a one-cycle response pulse or a timeout.
module mem_bus_initiator
  import mem_bus_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_wr,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_timeout,
  output logic              o_busy,
  output logic              o_bus_enable,
  output logic              o_bus_wr_en,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ready,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  localparam int unsigned ReqW   = 1 + ADDR_W + DATA_W;
  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  state_e              r_state, w_state_d;
  logic [TimerW-1:0]   r_timer, w_timer_d;
  logic                r_bus_enable, w_bus_enable_d;
  logic                r_bus_wr_en, w_bus_wr_en_d;
  logic [ADDR_W-1:0]   r_bus_addr, w_bus_addr_d;
  logic [DATA_W-1:0]   r_bus_wdata, w_bus_wdata_d;
  logic                r_rsp_valid, w_rsp_valid_d;
  logic                r_rsp_wr, w_rsp_wr_d;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_d;
  logic                r_rsp_timeout, w_rsp_timeout_d;

  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_pop;
  logic [ReqW-1:0]     w_head;
  logic                w_head_wr;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_wdata;
  logic                w_timer_expired;

  bus_req_fifo #(
    .WIDTH (ReqW),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (i_req_valid),
    .i_wdata ({i_req_wr, i_req_addr, i_req_wdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign {w_head_wr, w_head_addr, w_head_wdata} = w_head;

  // Head is consumed only when the bus is free; Release always passes through Idle first
  assign w_pop = (r_state == StIdle) && !w_fifo_empty;

  // Timer holds the number of completed enable cycles minus one at each Issue edge
  assign w_timer_expired = (r_timer >= TimerW'(TIMEOUT - 1));

  assign o_req_ready   = !w_fifo_full;
  assign o_busy        = !w_fifo_empty || (r_state != StIdle);
  assign o_bus_enable  = r_bus_enable;
  assign o_bus_wr_en   = r_bus_wr_en;
  assign o_bus_addr    = r_bus_addr;
  assign o_bus_wdata   = r_bus_wdata;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_wr      = r_rsp_wr;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_timeout = r_rsp_timeout;

  // State and all registered outputs; reset drops any in-flight transaction silently
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_timer       <= '0;
      r_bus_enable  <= 1'b0;
      r_bus_wr_en   <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_wdata   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_wr      <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_timer       <= w_timer_d;
      r_bus_enable  <= w_bus_enable_d;
      r_bus_wr_en   <= w_bus_wr_en_d;
      r_bus_addr    <= w_bus_addr_d;
      r_bus_wdata   <= w_bus_wdata_d;
      r_rsp_valid   <= w_rsp_valid_d;
      r_rsp_wr      <= w_rsp_wr_d;
      r_rsp_rdata   <= w_rsp_rdata_d;
      r_rsp_timeout <= w_rsp_timeout_d;
    end
  end

  // Next-state: a ready arriving on the expiry cycle is taken as success
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (!w_fifo_empty) begin
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        if (i_bus_ready || w_timer_expired) begin
          w_state_d = StRelease;
        end
      end
      StRelease: begin
        if (!i_bus_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Next values of bus and response registers; rsp_* hold between pulses
  always_comb begin
    w_timer_d       = r_timer;
    w_bus_enable_d  = r_bus_enable;
    w_bus_wr_en_d   = r_bus_wr_en;
    w_bus_addr_d    = r_bus_addr;
    w_bus_wdata_d   = r_bus_wdata;
    w_rsp_valid_d   = 1'b0;
    w_rsp_wr_d      = r_rsp_wr;
    w_rsp_rdata_d   = r_rsp_rdata;
    w_rsp_timeout_d = r_rsp_timeout;
    unique case (r_state)
      StIdle: begin
        w_bus_enable_d = 1'b0;
        if (!w_fifo_empty) begin
          w_bus_enable_d = 1'b1;
          w_bus_wr_en_d  = w_head_wr;
          w_bus_addr_d   = w_head_addr;
          w_bus_wdata_d  = w_head_wdata;
          w_timer_d      = '0;
        end
      end
      StIssue: begin
        if (i_bus_ready) begin
          w_bus_enable_d  = 1'b0;
          w_rsp_valid_d   = 1'b1;
          w_rsp_wr_d      = r_bus_wr_en;
          w_rsp_rdata_d   = r_bus_wr_en ? '0 : i_bus_rdata;
          w_rsp_timeout_d = 1'b0;
        end else if (w_timer_expired) begin
          w_bus_enable_d  = 1'b0;
          w_rsp_valid_d   = 1'b1;
          w_rsp_wr_d      = r_bus_wr_en;
          w_rsp_rdata_d   = '0;
          w_rsp_timeout_d = 1'b1;
        end else if (r_timer != TimerW'(TIMEOUT)) begin
          w_timer_d = r_timer + TimerW'(1);
        end
      end
      StRelease: begin
        w_bus_enable_d = 1'b0;
      end
      default: begin
        w_bus_enable_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator with a behavioural enable/ready responder
// (ready two cycles after enable, cleared once enable is seen low).
module tb_mem_bus_initiator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_wr;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       busy;
  logic       bus_enable;
  logic       bus_wr_en;
  logic [2:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_ready = 1'b0;
  logic [7:0] bus_rdata;

  // Responder controls
  logic       never_ready = 1'b0;
  logic       hold_ready = 1'b0;
  int         hold_cfg = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_bus_initiator #(
    .ADDR_W     (3),
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .TIMEOUT    (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_wr      (req_wr),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_wr      (rsp_wr),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_timeout (rsp_timeout),
    .o_busy        (busy),
    .o_bus_enable  (bus_enable),
    .o_bus_wr_en   (bus_wr_en),
    .o_bus_addr    (bus_addr),
    .o_bus_wdata   (bus_wdata),
    .i_bus_ready   (bus_ready),
    .i_bus_rdata   (bus_rdata)
  );

  // Responder read data: fixed per-address table
  function automatic logic [7:0] rom(input logic [2:0] a);
    case (a)
      3'd2:    rom = 8'h5C;
      3'd7:    rom = 8'h77;
      default: rom = {5'b10101, a};
    endcase
  endfunction

  assign bus_rdata = rom(bus_addr);

  // Behavioural responder
  int         resp_cnt = 0;
  int         hold_left = 0;
  logic [7:0] wr_log [8] = '{default: 8'h00};

  always @(posedge clk) begin
    if (bus_enable) begin
      hold_left <= hold_cfg;
      if (!never_ready) begin
        if (resp_cnt == 1) bus_ready <= 1'b1;
        resp_cnt <= resp_cnt + 1;
      end
      if (bus_ready && bus_wr_en) wr_log[bus_addr] <= bus_wdata;
    end else begin
      resp_cnt <= 0;
      if (bus_ready && !hold_ready) begin
        if (hold_left != 0) hold_left <= hold_left - 1;
        else bus_ready <= 1'b0;
      end
    end
  end

  // Bus / response monitor, sampled on the falling edge
  int         rsp_cnt = 0;
  int         rises = 0;
  int         run = 0;
  int         last_run = 0;
  int         stab_err = 0;
  int         drop_err = 0;
  int         order_err = 0;
  logic       prev_en = 1'b0;
  logic       prev_ready = 1'b0;
  logic       cap_wr = 1'b0;
  logic [2:0] cap_addr = '0;
  logic [7:0] cap_wdata = '0;
  logic       log_wr [64];
  logic [7:0] log_rdata [64];
  logic       log_to [64];

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      log_wr[rsp_cnt]    <= rsp_wr;
      log_rdata[rsp_cnt] <= rsp_rdata;
      log_to[rsp_cnt]    <= rsp_timeout;
      rsp_cnt            <= rsp_cnt + 1;
    end
    if (bus_enable === 1'b1) begin
      if (!prev_en) begin
        rises     <= rises + 1;
        run       <= 1;
        cap_wr    <= bus_wr_en;
        cap_addr  <= bus_addr;
        cap_wdata <= bus_wdata;
        // A new strobe must only follow a bus that has seen ready low
        if (bus_ready || prev_ready) order_err <= order_err + 1;
      end else begin
        run <= run + 1;
        if (bus_wr_en !== cap_wr || bus_addr !== cap_addr || bus_wdata !== cap_wdata)
          stab_err <= stab_err + 1;
      end
    end else if (prev_en) begin
      last_run <= run;
    end
    // Ready seen with enable high: enable must drop with a response pulse
    if (prev_en && prev_ready && (bus_enable !== 1'b0 || rsp_valid !== 1'b1))
      drop_err <= drop_err + 1;
    prev_en    <= (bus_enable === 1'b1);
    prev_ready <= bus_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [2:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int n);
    for (int i = 0; i < 100 && rsp_cnt < n; i++) tick();
    check(tag, rsp_cnt, n);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy !== 1'b0; i++) tick();
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  int b;
  int k;

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_enable", {31'd0, bus_enable}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("rst_bus_addr", {29'd0, bus_addr}, 32'd0);
    rst = 1'b1;
    tick();

    // 1: write 3 <- A5, enable latency and held bus fields
    push(1'b1, 3'd3, 8'hA5);
    check("t1_en_before", {31'd0, bus_enable}, 32'd0);
    tick();
    check("t1_en_after", {31'd0, bus_enable}, 32'd1);
    check("t1_wr_en", {31'd0, bus_wr_en}, 32'd1);
    check("t1_addr", {29'd0, bus_addr}, 32'd3);
    check("t1_wdata", {24'd0, bus_wdata}, 32'hA5);
    wait_rsp("t1_rsp_cnt", 1);
    check("t1_rsp_wr", {31'd0, log_wr[0]}, 32'd1);
    check("t1_rsp_rdata", {24'd0, log_rdata[0]}, 32'd0);
    check("t1_rsp_to", {31'd0, log_to[0]}, 32'd0);
    check("t1_wr_log", {24'd0, wr_log[3]}, 32'hA5);
    check("t1_run", last_run, 3);

    // 2: read 2 -> 5C
    wait_idle("t2_idle");
    push(1'b0, 3'd2, 8'h00);
    wait_rsp("t2_rsp_cnt", 2);
    check("t2_rsp_wr", {31'd0, log_wr[1]}, 32'd0);
    check("t2_rsp_rdata", {24'd0, log_rdata[1]}, 32'h5C);
    check("t2_rsp_to", {31'd0, log_to[1]}, 32'd0);
    check("t2_drop", drop_err, 0);

    // 3: bus held in Release while 4 more requests fill the FIFO; 5th must stall
    wait_idle("t3_idle");
    b = rsp_cnt;
    hold_ready = 1'b1;
    push(1'b0, 3'd7, 8'h00);
    wait_rsp("t3_first", b + 1);
    check("t3_first_rdata", {24'd0, log_rdata[b]}, 32'h77);
    push(1'b1, 3'd4, 8'h14);
    push(1'b1, 3'd5, 8'h15);
    push(1'b0, 3'd3, 8'h00);
    push(1'b1, 3'd6, 8'h16);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 3'd7;
    req_wdata = 8'h00;
    check("t3_full_ready", {31'd0, req_ready}, 32'd0);
    tick();
    tick();
    check("t3_still_full", {31'd0, req_ready}, 32'd0);
    check("t3_no_enable", {31'd0, bus_enable}, 32'd0);
    hold_ready = 1'b0;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("t3_admit", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    wait_rsp("t3_rsp_cnt", b + 6);
    check("t3_r1_wr", {31'd0, log_wr[b+1]}, 32'd1);
    check("t3_r2_wr", {31'd0, log_wr[b+2]}, 32'd1);
    check("t3_r3_wr", {31'd0, log_wr[b+3]}, 32'd0);
    check("t3_r3_rdata", {24'd0, log_rdata[b+3]}, 32'hAB);
    check("t3_r4_wr", {31'd0, log_wr[b+4]}, 32'd1);
    check("t3_r5_rdata", {24'd0, log_rdata[b+5]}, 32'h77);
    check("t3_log4", {24'd0, wr_log[4]}, 32'h14);
    check("t3_log5", {24'd0, wr_log[5]}, 32'h15);
    check("t3_log6", {24'd0, wr_log[6]}, 32'h16);
    for (int i = 0; i < 20; i++) tick();
    check("t3_exact_cnt", rsp_cnt, b + 6);

    // 4: timeout after exactly 8 enable cycles, then a normal read
    b = rsp_cnt;
    never_ready = 1'b1;
    push(1'b0, 3'd1, 8'h00);
    wait_rsp("t4_rsp_cnt", b + 1);
    check("t4_to", {31'd0, log_to[b]}, 32'd1);
    check("t4_rdata", {24'd0, log_rdata[b]}, 32'd0);
    check("t4_run", last_run, 8);
    never_ready = 1'b0;
    wait_idle("t4_idle");
    push(1'b0, 3'd2, 8'h00);
    wait_rsp("t4_next_cnt", b + 2);
    check("t4_next_to", {31'd0, log_to[b+1]}, 32'd0);
    check("t4_next_rdata", {24'd0, log_rdata[b+1]}, 32'h5C);

    // 5: reset during Issue with two requests queued
    wait_idle("t5_idle");
    never_ready = 1'b1;
    push(1'b0, 3'd1, 8'h00);
    push(1'b0, 3'd2, 8'h00);
    push(1'b0, 3'd3, 8'h00);
    check("t5_pre_enable", {31'd0, bus_enable}, 32'd1);
    b = rsp_cnt;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t5_enable", {31'd0, bus_enable}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_req_ready", {31'd0, req_ready}, 32'd1);
    check("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t5_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    check("t5_no_rsp", rsp_cnt, b);
    never_ready = 1'b0;
    push(1'b1, 3'd6, 8'h3C);
    wait_rsp("t5_after_cnt", b + 1);
    check("t5_after_to", {31'd0, log_to[b]}, 32'd0);
    check("t5_after_log", {24'd0, wr_log[6]}, 32'h3C);

    // 6: responder keeps ready 3 cycles after enable drops
    wait_idle("t6_idle");
    b = rsp_cnt;
    hold_cfg = 3;
    push(1'b1, 3'd1, 8'h61);
    push(1'b1, 3'd2, 8'h62);
    wait_rsp("t6_rsp_cnt", b + 2);
    check("t6_log1", {24'd0, wr_log[1]}, 32'h61);
    check("t6_log2", {24'd0, wr_log[2]}, 32'h62);
    check("t6_order", order_err, 0);
    hold_cfg = 0;
    wait_idle("t6_end_idle");

    // Global bus-protocol tallies; the reset-aborted strobe is the one without a response
    check("g_stable", stab_err, 0);
    check("g_drop", drop_err, 0);
    check("g_order", order_err, 0);
    check("g_rises", rises, rsp_cnt + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
